// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared decode constants, FSM state type and operand-signedness helpers for
// the RV32M multiply/divide sequencer.
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] FNC7_MULDIV   = 7'b0000001;

    localparam logic [2:0] FNC3_MUL    = 3'b000;
    localparam logic [2:0] FNC3_MULH   = 3'b001;
    localparam logic [2:0] FNC3_MULHSU = 3'b010;
    localparam logic [2:0] FNC3_MULHU  = 3'b011;
    localparam logic [2:0] FNC3_DIV    = 3'b100;
    localparam logic [2:0] FNC3_DIVU   = 3'b101;
    localparam logic [2:0] FNC3_REM    = 3'b110;
    localparam logic [2:0] FNC3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // MUL (low half) is sign-agnostic, so it is run unsigned.
    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return f3 inside {FNC3_MULH, FNC3_MULHSU, FNC3_DIV, FNC3_REM};
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return f3 inside {FNC3_MULH, FNC3_DIV, FNC3_REM};
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
// Operand magnitude/sign capture, 64-bit accumulator shared by shift-add
// multiply and restoring divide, special divide results and final sign fix.
//   i_clk, i_rst        clock, synchronous active-high reset (clears result)
//   i_load              latch operands / special result (start accepted)
//   i_funct3            operation select at load time
//   i_rs1, i_rs2        operand values
//   i_mul_step          perform one multiply step
//   i_div_step          perform one divide step
//   i_finish            last step: sign-fix and register the result
//   o_special           combinational: divide-by-zero or signed overflow
//   o_result            registered result
// -----------------------------------------------------------------------------
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_mul_step,
    input  logic            i_div_step,
    input  logic            i_finish,
    output logic            o_special,
    output logic [XLEN-1:0] o_result
);

    logic [63:0]     r_acc;     // mul: {partial hi, multiplier}; div: {rem, quo}
    logic [XLEN-1:0] r_opb;     // multiplicand or divisor magnitude
    logic [2:0]      r_op;
    logic            r_neg;

    logic            w_neg1, w_neg2, w_is_rem, w_div_zero, w_ovf;
    logic [XLEN-1:0] w_mag1, w_mag2, w_special_res, w_val, w_fixed;
    logic [32:0]     w_mul_sum, w_div_diff;
    logic            w_div_ok;
    logic [63:0]     w_acc_next, w_prod;

    assign w_neg1   = rs1_is_signed(i_funct3) & i_rs1[XLEN-1];
    assign w_neg2   = rs2_is_signed(i_funct3) & i_rs2[XLEN-1];
    assign w_mag1   = w_neg1 ? -i_rs1 : i_rs1;
    assign w_mag2   = w_neg2 ? -i_rs2 : i_rs2;
    assign w_is_rem = i_funct3[2] & i_funct3[1];

    assign w_div_zero = (i_rs2 == '0);
    assign w_ovf      = !i_funct3[0] && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
    assign o_special  = i_funct3[2] && (w_div_zero || w_ovf);

    always_comb begin
        if (w_div_zero) w_special_res = w_is_rem ? i_rs1 : 32'hFFFF_FFFF;
        else            w_special_res = w_is_rem ? 32'h0 : 32'h8000_0000;
    end

    // Multiply step: conditional add into the upper half, then shift right
    // with the carry entering at bit 63.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);

    // Divide step on the shifted remainder r_acc[63:31]. When r_acc[63] is
    // set the 33-bit value already exceeds any divisor, so the borrow bit
    // alone cannot be trusted there.
    assign w_div_diff = r_acc[63:31] - {1'b0, r_opb};
    assign w_div_ok   = r_acc[63] | ~w_div_diff[32];

    always_comb begin
        if (i_div_step)
            w_acc_next = w_div_ok ? {w_div_diff[31:0], r_acc[30:0], 1'b1}
                                  : {r_acc[62:0], 1'b0};
        else
            w_acc_next = {w_mul_sum, r_acc[31:1]};
    end

    // Sign fix works on the post-step accumulator so the result can be
    // registered on the same edge that enters DONE.
    assign w_prod = r_neg ? -w_acc_next : w_acc_next;
    assign w_val  = r_op[1] ? w_acc_next[63:32] : w_acc_next[31:0];

    always_comb begin
        if (!r_op[2]) w_fixed = (r_op == FNC3_MUL) ? w_prod[31:0] : w_prod[63:32];
        else          w_fixed = r_neg ? -w_val : w_val;
    end

    // NOTE: working registers are always overwritten by i_load before use,
    // so only the architecturally visible result carries a reset.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_op  <= i_funct3;
            r_neg <= w_is_rem ? w_neg1 : (w_neg1 ^ w_neg2);
            r_acc <= {32'h0, i_funct3[2] ? w_mag1 : w_mag2};
            r_opb <= i_funct3[2] ? w_mag2 : w_mag1;
        end else if (i_mul_step || i_div_step) begin
            r_acc <= w_acc_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_result <= '0;
        else if (i_load && o_special)
            o_result <= w_special_res;
        else if (i_finish)
            o_result <= w_fixed;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Execute-stage RV32M sequencer: decodes muldiv instructions, stalls the
// pipeline during the 32-step iteration and pulses result_valid for a cycle.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid_in          execute-stage instruction valid
//   i_instruction       execute-stage instruction (held while o_stall)
//   i_rs1_data/rs2_data forwarded operands
//   i_kill              flush; aborts any operation
//   o_is_muldiv         combinational decode
//   o_stall             hold IF/ID/EX
//   o_result_valid      o_result valid this cycle
//   o_result            registered result
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid_in,
    input  logic [31:0]     i_instruction,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_kill,
    output logic            o_is_muldiv,
    output logic            o_stall,
    output logic            o_result_valid,
    output logic [XLEN-1:0] o_result
);

    state_t     r_state, w_state_next;
    logic [5:0] r_cnt;
    logic       w_abort, w_start, w_special, w_last;
    logic       w_mul_step, w_div_step, w_finish;
    logic [2:0] w_funct3;
    logic       w_unused_fields;

    assign w_funct3        = i_instruction[14:12];
    assign w_unused_fields = ^{i_instruction[24:15], i_instruction[11:7]};

    assign o_is_muldiv = (i_instruction[6:0] == OPC_ARI_RTYPE) &&
                         (i_instruction[31:25] == FNC7_MULDIV);

    assign w_abort = i_kill | i_rst;
    assign w_start = (r_state == ST_IDLE) && i_valid_in && o_is_muldiv && !w_abort;
    assign w_last  = (r_cnt == 6'd31);

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        o_stall        = 1'b0;
        o_result_valid = 1'b0;
        w_mul_step     = 1'b0;
        w_div_step     = 1'b0;
        w_finish       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    o_stall      = 1'b1;
                    w_state_next = w_special   ? ST_DONE :
                                   w_funct3[2] ? ST_DIV  : ST_MUL;
                end
            end
            ST_MUL: begin
                o_stall    = 1'b1;
                w_mul_step = 1'b1;
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DIV: begin
                o_stall    = 1'b1;
                w_div_step = 1'b1;
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // valid_in is ignored here: the held instruction must not restart.
                o_result_valid = 1'b1;
                w_state_next   = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_next   = ST_IDLE;
            o_stall        = 1'b0;
            o_result_valid = 1'b0;
            w_mul_step     = 1'b0;
            w_div_step     = 1'b0;
            w_finish       = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in the design samples the values from before this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start)
                r_cnt <= '0;
            else if (w_mul_step || w_div_step)
                r_cnt <= r_cnt + 6'd1;
        end
    end

    muldiv_datapath u_datapath (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_start),
        .i_funct3   (w_funct3),
        .i_rs1      (i_rs1_data),
        .i_rs2      (i_rs2_data),
        .i_mul_step (w_mul_step),
        .i_div_step (w_div_step),
        .i_finish   (w_finish),
        .o_special  (w_special),
        .o_result   (o_result)
    );

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide sequencer in the execute stage, beside the ALU. It decodes R-type instructions with funct7 = 7'b0000001, latches operands, and runs a 32-step shift-add multiply or restoring divide. While an operation is in flight it stalls the pipeline, then presents the 32-bit result for one cycle to the writeback mux.

## Interface
- XLEN, 32, operand and result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  the instruction in the execute stage is valid.
- instruction  in  32  instruction in the execute stage; held stable by the pipeline while stall=1.
- rs1_data  in  XLEN  forwarded rs1 value.
- rs2_data  in  XLEN  forwarded rs2 value.
- kill  in  1  flush; aborts any operation.
- is_muldiv  out  1  combinational decode: opcode == OPC_ARI_RTYPE && funct7 == 7'b0000001.
- stall  out  1  holds the IF/ID/EX stages.
- result_valid  out  1  result is valid this cycle.
- result  out  XLEN  registered result.

## Operation
- funct3 selects the operation:
  - 000 MUL, low 32 bits.
  - 001 MULH, signed×signed, high 32 bits.
  - 010 MULHSU, signed rs1 × unsigned rs2, high 32 bits.
  - 011 MULHU, unsigned×unsigned, high 32 bits.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start = valid_in && is_muldiv && !kill.
  - On start, latch the magnitudes of the operands. An operand is negated only if it is negative and its operation treats it as signed.
  - Latch neg_res for the result sign:
    - Products: XOR of the operand signs.
    - Quotients: XOR of the operand signs.
    - Remainders: sign of the dividend.
  - Clear the 6-bit step counter.
  - Next state: MUL, DIV, or DONE (special divide cases).
- MUL: one step per cycle.
  - If multiplier bit0 is set, add the multiplicand into the upper half of the 64-bit accumulator.
  - Shift the accumulator right by 1 (33-bit add including carry).
  - After 32 steps, go to DONE.
- DIV: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor (33-bit).
  - If the result is non-negative, keep it and set quo bit0.
  - After 32 steps, go to DONE.
- Special divide cases, decided in IDLE with no iteration:
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Entering DONE:
  - Apply the sign fix: two's complement over 64 bits for products, over 32 bits for quotient/remainder.
  - Select the high or low half, or quotient or remainder, and register it into result.
- DONE: result_valid = 1 for exactly one cycle, then IDLE unconditionally. valid_in is ignored in DONE, so the held instruction does not restart.
- stall = start || state ∈ {MUL, DIV}. stall is 0 in DONE so the pipeline advances.
- kill in any state:
  - Next state IDLE.
  - stall = 0 and result_valid = 0 in that cycle.
  - result is unchanged.
- rst has the same effect as kill and also clears result. Reset values: stall 0, result_valid 0, result 0, state IDLE.

## Timing
- Start accepted at cycle T; stall=1 combinationally from T.
- MUL/DIV: iterations at T+1..T+32; DONE at T+33 with result_valid=1 and stall=0. Latency is 33 cycles; stall is high for cycles T..T+32.
- Special divide cases: DONE at T+1; stall high only at T.
- A back-to-back muldiv instruction in the next stage arrives while the block is in IDLE, at T+34 or later, and starts normally.
- kill together with start at T: no start.
- kill at DONE: result_valid is suppressed.

## Structure
- Add FNC7_MULDIV and the eight funct3 codes to Opcode.vh. State encodings are local parameters.
- One sub-module, muldiv_datapath, holds the accumulator and divide registers, the 33-bit add/subtract, and the sign fix. muldiv_sequencer owns the FSM, counter, decode and stall.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD: stall for 33 cycles, then result = 0xFFFFFFEB with a single-cycle result_valid.
- MULH, 0x80000000 × 0x80000000: result = 0x40000000. MULHU, 0xFFFFFFFF × 0xFFFFFFFF: result = 0xFFFFFFFE. MULHSU, 0xFFFFFFFF × 2: result = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: 0x80000000. REM of the same operands: 0. DIVU 5/0: 0xFFFFFFFF. REMU 5/0: 5. All at T+1, with stall high only at T.
- REM −7 % 2: 0xFFFFFFFF. DIV −7 / 2: 0xFFFFFFFD. DIVU 100/7: 14, after 33 cycles.
- kill at T+10 of a DIV: stall low in that cycle, IDLE at T+11, no result_valid, result unchanged.
- rst mid-MUL: all outputs 0 on the next cycle. Then two consecutive MULs produce two result_valid pulses, 34 cycles apart.
